// File: rtl/instr_pkg.sv
// instr_pkg: module selects, opcodes, fetch states and the power-on program
package instr_pkg;
  localparam logic [3:0] MainMemEn    = 4'd0;
  localparam logic [3:0] InstrMemEn   = 4'd1;
  localparam logic [3:0] MatrixAluEn  = 4'd2;
  localparam logic [3:0] IntegerAluEn = 4'd3;
  localparam logic [3:0] ExecuteEn    = 4'd4;
  localparam logic [7:0] MMult      = 8'h00;
  localparam logic [7:0] MAdd       = 8'h01;
  localparam logic [7:0] MSub       = 8'h02;
  localparam logic [7:0] MTranspose = 8'h03;
  localparam logic [7:0] MScale     = 8'h04;
  localparam logic [7:0] MScaleImm  = 8'h05;
  localparam logic [7:0] IntAdd     = 8'h10;
  localparam logic [7:0] IntSub     = 8'h11;
  localparam logic [7:0] IntMult    = 8'h12;
  localparam logic [7:0] IntDiv     = 8'h13;
  localparam logic [7:0] Stop       = 8'hFF;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} fetch_state_t;
  localparam logic [255:0] PROG_LINE0 = {32'h01020001, 32'h10100908, 32'h02030200, 32'h03040200,
                                         32'h04050310, 32'h00060403, 32'h120A0100, 32'h11110A01};
  localparam logic [255:0] PROG_LINE1 = {32'h130B0A11, 32'hFF000000, 192'h0};
  // Lines beyond the first two of the default program are empty.
  function automatic logic [255:0] default_prog(input int i);
    return (i == 0) ? PROG_LINE0 : (i == 1) ? PROG_LINE1 : '0;
  endfunction
endpackage

// File: rtl/instr_line_ram.sv
// instr_line_ram: DEPTH x line store, bus and sequencer read ports, one write port, reset preload
module instr_line_ram
  import instr_pkg::*;
#(
  parameter int LW = 256,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [LW-1:0] wdata,
  input  logic [11:0]   bus_idx,
  output logic [LW-1:0] bus_line,
  input  logic [AW-1:0] seq_idx,
  output logic [LW-1:0] seq_line
);
  logic [LW-1:0] mem [DEPTH];
  // Reset reloads the default program; otherwise one line may be written per edge.
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= LW'(default_prog(i));
    else if (we)
      mem[waddr] <= wdata;
  // Reads are combinational so registered consumers see pre-write data on a same-cycle load.
  always_comb begin
    bus_line = (bus_idx < 12'(DEPTH)) ? mem[bus_idx[AW-1:0]] : '0;
    seq_line = mem[seq_idx];
  end
endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: instruction store with legacy bus line read, line load and a stop-aware fetch sequencer
module instr_fetch_seq
  import instr_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int LINE_N = 8,
  parameter int DEPTH = 4,
  parameter logic [3:0] MOD_ID = InstrMemEn,
  parameter logic [7:0] STOP_OP = Stop,
  localparam int LW = INSTR_W * LINE_N,
  localparam int LA = $clog2(DEPTH),
  localparam int SA = $clog2(LINE_N),
  localparam int PA = $clog2(DEPTH * LINE_N)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [15:0]        address,
  input  logic               nRead,
  output logic [LW-1:0]      InstructDataOut,
  input  logic               LoadEn,
  input  logic [LA-1:0]      LoadAddr,
  input  logic [LW-1:0]      LoadData,
  input  logic               Start,
  input  logic               Ready,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [PA-1:0]      Pc,
  output logic               Busy,
  output logic               Halted,
  output logic               Overrun
);
  fetch_state_t state;
  logic [LA-1:0] line;
  logic [SA-1:0] slot;
  logic [LW-1:0] linebuf;
  logic [LW-1:0] bus_line;
  logic [LW-1:0] seq_line;
  // Slot 0 is the most significant word of a line and executes first.
  function automatic logic [INSTR_W-1:0] slot_word(input logic [LW-1:0] l, input logic [SA-1:0] k);
    return l[INSTR_W*(LINE_N-1-int'(k)) +: INSTR_W];
  endfunction
  instr_line_ram #(.LW(LW), .DEPTH(DEPTH)) u_ram (
    .clk(Clk),
    .rst(Reset),
    .we(LoadEn),
    .waddr(LoadAddr),
    .wdata(LoadData),
    .bus_idx(address[11:0]),
    .bus_line(bus_line),
    .seq_idx(line),
    .seq_line(seq_line)
  );
  // Legacy bus read: one-cycle registered line when this module is selected with nRead low.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) InstructDataOut <= '0;
    else if (address[15:12] == MOD_ID && !nRead) InstructDataOut <= bus_line;
  // Sequencer: FETCH buffers a line, ISSUE hands out one slot per handshake, stops on STOP_OP or overrun.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      line <= '0;
      slot <= '0;
      linebuf <= '0;
      InstrValid <= 1'b0;
      InstrOut <= '0;
      Pc <= '0;
      Busy <= 1'b0;
      Halted <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT:
          if (Start) begin
            state <= FETCH;
            line <= '0;
            slot <= '0;
            Overrun <= 1'b0;
            Busy <= 1'b1;
            Halted <= 1'b0;
          end
        FETCH: begin
          linebuf <= seq_line;
          slot <= '0;
          InstrOut <= slot_word(seq_line, '0);
          Pc <= PA'(line) * PA'(LINE_N);
          InstrValid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE:
          if (Ready) begin
            if (InstrOut[INSTR_W-1 -: 8] == STOP_OP) begin
              state <= HALT;
              InstrValid <= 1'b0;
              Busy <= 1'b0;
              Halted <= 1'b1;
            end else if (slot < SA'(LINE_N - 1)) begin
              slot <= slot + SA'(1);
              InstrOut <= slot_word(linebuf, slot + SA'(1));
              Pc <= Pc + PA'(1);
            end else if (line < LA'(DEPTH - 1)) begin
              line <= line + LA'(1);
              state <= FETCH;
              InstrValid <= 1'b0;
            end else begin
              Overrun <= 1'b1;
              state <= HALT;
              InstrValid <= 1'b0;
              Busy <= 1'b0;
              Halted <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed stimulus with a queued scoreboard checked at every issue handshake
module tb_instr_fetch_seq;
  import instr_pkg::*;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [15:0] address = '0;
  logic nRead = 1'b1;
  logic [255:0] InstructDataOut;
  logic LoadEn = 1'b0;
  logic [1:0] LoadAddr = '0;
  logic [255:0] LoadData = '0;
  logic Start = 1'b0;
  logic Ready = 1'b0;
  logic InstrValid;
  logic [31:0] InstrOut;
  logic [4:0] Pc;
  logic Busy, Halted, Overrun;
  int compared = 0;
  int mismatched = 0;
  typedef struct {logic [4:0] pc; logic [31:0] instr;} exp_t;
  exp_t q[$];
  logic [31:0] prog [8] = '{32'h01020001, 32'h10100908, 32'h02030200, 32'h03040200,
                            32'h04050310, 32'h00060403, 32'h120A0100, 32'h11110A01};
  logic [255:0] line0 = {32'h01020001, 32'h10100908, 32'h02030200, 32'h03040200,
                         32'h04050310, 32'h00060403, 32'h120A0100, 32'h11110A01};
  logic [255:0] line1 = {32'h130B0A11, 32'hFF000000, 192'h0};
  logic [255:0] new1 = {32'h11000001, 32'hFF000002, 192'h0};
  logic [255:0] fill = {8{32'h10000000}};
  bit hold_v = 1'b0;
  logic [31:0] hold_i;
  logic [4:0] hold_p;
  int cyc;

  instr_fetch_seq dut (
    .Clk(Clk), .Reset(Reset), .address(address), .nRead(nRead),
    .InstructDataOut(InstructDataOut), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .Start(Start), .Ready(Ready), .InstrValid(InstrValid),
    .InstrOut(InstrOut), .Pc(Pc), .Busy(Busy), .Halted(Halted), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [4:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    q.push_back(e);
  endtask

  task automatic push_prog(input logic [31:0] w8, input logic [31:0] w9);
    for (int i = 0; i < 8; i++) push(5'(i), prog[i]);
    push(5'd8, w8);
    push(5'd9, w9);
  endtask

  task automatic run_prog(input bit toggle, input bit ld1, output int n);
    n = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    while (!Halted && n < 200) begin
      if (ld1 && Busy && !InstrValid && Pc == 5'd7) begin
        LoadEn = 1'b1;
        LoadAddr = 2'd1;
        LoadData = new1;
      end
      if (toggle) Ready = ~Ready;
      tick();
      n++;
      LoadEn = 1'b0;
    end
    check("halt_reached", 256'(Halted), 256'(1));
    check("queue_drained", 256'(q.size()), 256'(0));
  endtask

  // Monitor: every accepted instruction must match the scoreboard head; a stalled one must hold.
  always @(negedge Clk) begin
    if (Reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && InstrValid) begin
        check("hold_instr", 256'(InstrOut), 256'(hold_i));
        check("hold_pc", 256'(Pc), 256'(hold_p));
      end
      hold_v = InstrValid && !Ready;
      hold_i = InstrOut;
      hold_p = Pc;
      if (InstrValid && Ready) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_issue: got pc %0d instr %h, no issue expected", Pc, InstrOut);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("issue_pc", 256'(Pc), 256'(e.pc));
          check("issue_instr", 256'(InstrOut), 256'(e.instr));
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_valid", 256'(InstrValid), 256'(0));
    check("rst_busy", 256'({Busy, Halted, Overrun}), 256'(0));
    check("rst_bus", InstructDataOut, 256'(0));
    @(posedge Clk);
    #1 Reset = 1'b0;
    address = 16'h1000; nRead = 1'b0; tick();
    check("bus_line0", InstructDataOut, line0);
    address = 16'h0000; tick();
    check("bus_other_module", InstructDataOut, line0);
    address = 16'h1001; tick();
    check("bus_line1", InstructDataOut, line1);
    address = 16'h1005; tick();
    check("bus_out_of_range", InstructDataOut, 256'(0));
    address = 16'h1000; nRead = 1'b1; tick();
    check("bus_nread_high", InstructDataOut, 256'(0));
    Ready = 1'b1;
    push_prog(32'h130B0A11, 32'hFF000000);
    run_prog(1'b0, 1'b0, cyc);
    check("run_cycles", 256'(cyc), 256'(12));
    check("stop_overrun", 256'(Overrun), 256'(0));
    Ready = 1'b1;
    push_prog(32'h130B0A11, 32'hFF000000);
    run_prog(1'b1, 1'b0, cyc);
    check("toggle_overrun", 256'(Overrun), 256'(0));
    nRead = 1'b0; tick(); nRead = 1'b1;
    Ready = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    cyc = 0;
    while (!InstrValid && cyc < 10) begin tick(); cyc++; end
    check("mid_valid", 256'(InstrValid), 256'(1));
    for (int i = 0; i < 3; i++) push(5'(i), prog[i]);
    Ready = 1'b1;
    repeat (3) tick();
    Ready = 1'b0;
    check("mid_pc", 256'(Pc), 256'(3));
    check("mid_instr", 256'(InstrOut), 256'(32'h03040200));
    #2 Reset = 1'b1;
    #1;
    check("async_valid", 256'({InstrValid, Busy, Halted, Overrun}), 256'(0));
    check("async_instr", 256'(InstrOut), 256'(0));
    check("async_pc", 256'(Pc), 256'(0));
    check("async_bus", InstructDataOut, 256'(0));
    check("async_state", 256'(dut.state), 256'(IDLE));
    check("mid_drained", 256'(q.size()), 256'(0));
    @(posedge Clk);
    #1 Reset = 1'b0;
    Ready = 1'b1;
    push_prog(32'h130B0A11, 32'hFF000000);
    run_prog(1'b0, 1'b0, cyc);
    check("restart_cycles", 256'(cyc), 256'(12));
    Ready = 1'b1;
    push_prog(32'h130B0A11, 32'hFF000000);
    run_prog(1'b0, 1'b1, cyc);
    check("rbw_overrun", 256'(Overrun), 256'(0));
    push_prog(32'h11000001, 32'hFF000002);
    run_prog(1'b0, 1'b0, cyc);
    check("newdata_overrun", 256'(Overrun), 256'(0));
    Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      LoadEn = 1'b1; LoadAddr = 2'(i); LoadData = fill; tick();
    end
    LoadEn = 1'b0;
    address = 16'h1002; nRead = 1'b0; tick(); nRead = 1'b1;
    check("bus_loaded", InstructDataOut, fill);
    for (int i = 0; i < 32; i++) push(5'(i), 32'h10000000);
    Ready = 1'b1;
    run_prog(1'b0, 1'b0, cyc);
    check("overrun_set", 256'(Overrun), 256'(1));
    check("overrun_busy", 256'(Busy), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
Parametrised instruction store with a built-in fetch sequencer. It keeps the legacy bus-read port, which returns one whole line when the address selects the instruction-memory module ID. It also adds three new features:
- a line-write load port;
- an instruction sequencer that walks the program and hands one instruction per valid/ready handshake to the execution engine;
- stop-opcode detection and halt.

Parameters:
INSTR_W, 32, bits per instruction (opcode in top 8 bits)
LINE_N, 8, instructions per line
DEPTH, 4, number of lines
MOD_ID, 1, value of address[15:12] that selects this block (InstrMemEn)
STOP_OP, 8'hFF, opcode that halts the sequencer

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
address  in  16  bus address; [15:12] module select, [11:0] line index
nRead  in  1  active-low bus read strobe
InstructDataOut  out  INSTR_W*LINE_N  registered bus read line
LoadEn  in  1  write enable for one line
LoadAddr  in  clog2(DEPTH)  line to write
LoadData  in  INSTR_W*LINE_N  line write data
Start  in  1  pulse: begin execution at instruction 0
Ready  in  1  consumer accepts InstrOut this cycle
InstrValid  out  1  InstrOut holds a valid instruction
InstrOut  out  INSTR_W  current instruction
Pc  out  clog2(DEPTH*LINE_N)  index of InstrOut, computed as line*LINE_N+slot
Busy  out  1  sequencer is in FETCH or ISSUE
Halted  out  1  sequencer is in HALT
Overrun  out  1  halt was caused by running past the last line, not by STOP_OP

Behaviour:
- Reset (asynchronous): all outputs go to 0; state goes to IDLE; memory is reloaded with DEFAULT_PROG from the package. Reset asserted mid-operation aborts immediately, and no handshake completes in that cycle.
- Slot order: slot k occupies bits [INSTR_W*(LINE_N-k)-1 : INSTR_W*(LINE_N-k-1)]. Slot 0 is the MSB word and executes first.
- Bus read: on the rising edge, if address[15:12]==MOD_ID and nRead==0, then InstructDataOut <= mem[address[11:0]].
  - Latency is 1 cycle.
  - An index >= DEPTH returns all zeros.
  - Otherwise InstructDataOut holds its value.
- Load: if LoadEn is high, mem[LoadAddr] <= LoadData on the edge.
  - A bus read or FETCH of the same line in the same cycle returns the old data (read-before-write).
  - Loading is allowed in any state. A load to the line already buffered does not alter the buffer.
- FSM states and transitions:
  - IDLE: on Start, set line=0, slot=0, Overrun=0, go to FETCH.
  - FETCH (1 cycle): linebuf <= mem[line], slot=0, go to ISSUE. InstrValid=0.
  - ISSUE: InstrValid=1 and InstrOut=linebuf[slot]. Outputs are stable until Ready. On Valid&&Ready:
    - if opcode==STOP_OP: go to HALT. The stop instruction itself is delivered.
    - else if slot<LINE_N-1: slot++.
    - else if line<DEPTH-1: line++, go to FETCH. This costs a 1-cycle bubble.
    - else: Overrun=1, go to HALT.
  - HALT: Halted=1, InstrValid=0. On Start: clear Overrun, set line=0, slot=0, go to FETCH.
- Start is ignored in FETCH and ISSUE.
- Ready while InstrValid==0 has no effect.
- Pc is valid whenever InstrValid is high and otherwise holds its last value.
- Bus read and sequencer operate independently; there is no arbitration because the memory has two read ports.

Decomposition:
- Package instr_pkg holds:
  - the module-select constants (MainMemEn=0, InstrMemEn=1, MatrixAluEn=2, IntegerAluEn=3, ExecuteEn=4);
  - the opcode constants (MMult 00 … MScaleImm 05, IntAdd 10 … IntDiv 13, Stop FF);
  - the fetch-state enum (IDLE, FETCH, ISSUE, HALT);
  - DEFAULT_PROG:
    - line0 = 01020001, 10100908, 02030200, 03040200, 04050310, 00060403, 120A0100, 11110A01
    - line1 = 130B0A11, FF000000, then zeros
    - lines 2-3 = zeros
- One sub-module: instr_line_ram, the DEPTH x line array with two read ports, one write port, and reset preload. The FSM stays in the top level.

Test Plan:
- Reset, then bus read with address=16'h1000, nRead=0: the next cycle InstructDataOut = line0 {01020001,…,11110A01}. With address=16'h0000, InstructDataOut is unchanged.
- Start with Ready held at 1: InstrOut sequence is 01020001 … 11110A01, bubble, 130B0A11, FF000000. Pc runs 0..9, then Halted=1 and Overrun=0. The run takes 12 cycles from Start to Halted.
- Ready toggled 1-0-1 during ISSUE: InstrOut and Pc hold while Ready=0, and no instruction is skipped or duplicated.
- Load all lines with no FF opcode (e.g. 10000000 in every slot), then Start: 32 instructions are issued, then Halted=1 and Overrun=1.
- LoadEn for line 1 in the same cycle as a FETCH of line 1: the first line-1 issue is 130B0A11 (old data). A restart via Start then issues the new data.
- Reset asserted mid-ISSUE at Pc=3: outputs go to 0 at once and the state is IDLE. After reset release and Start, execution restarts at Pc=0 with instruction 01020001.
